// File: rtl/bunch_fb_pkg.sv
// Shared state encoding, width defaults and helpers for the bunch feedback front end.
package bunch_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    INTEG,
    DONE
  } state_t;

  localparam int DEF_ADC_W    = 14;
  localparam int DEF_CHARGE_W = 21;

  // Counter width that can hold value-1, never narrower than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/bunch_integ_accum.sv
// Per-bunch accumulator: loads on the first sample of a bunch and adds on the rest.
// With BUNCH_CHARGE_PEDESTAL_SUB_EN the pedestal is subtracted through a one-cycle register.
module bunch_integ_accum
  import bunch_fb_pkg::*;
#(
  parameter int ADC_W    = DEF_ADC_W,
  parameter int CHARGE_W = DEF_CHARGE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [ADC_W-1:0]    sample,
  input  logic signed [ADC_W-1:0]    pedestal,
  input  logic                       first,
  input  logic                       enable,
  input  logic                       clear,
  output logic signed [CHARGE_W-1:0] acc
);

  logic signed [CHARGE_W-1:0] term;

`ifdef BUNCH_CHARGE_PEDESTAL_SUB_EN
  logic signed [ADC_W:0] diff_q;

  // One extra bit keeps the difference of two full-range samples exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
    end else begin
      diff_q <= {sample[ADC_W-1], sample} - {pedestal[ADC_W-1], pedestal};
    end
  end

  assign term = {{(CHARGE_W-ADC_W-1){diff_q[ADC_W]}}, diff_q};
`else
  logic unused_pedestal;

  assign unused_pedestal = ^pedestal;
  assign term            = {{(CHARGE_W-ADC_W){sample[ADC_W-1]}}, sample};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= first ? term : acc + term;
    end
  end

endmodule

// File: rtl/bunch_charge_integ.sv
// Integrates NUM_SMPLS_INTEG sum-channel samples per bunch over a train of NUM_BUNCHES bunches.
// Optional pedestal subtraction: define BUNCH_CHARGE_PEDESTAL_SUB_EN (adds one cycle of latency).
module bunch_charge_integ
  import bunch_fb_pkg::*;
#(
  parameter int NUM_SMPLS_INTEG = 4,
  parameter int NUM_BUNCHES     = 3,
  parameter int ADC_W           = DEF_ADC_W,
  parameter int CHARGE_W        = DEF_CHARGE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [ADC_W-1:0]    sum_in,
  input  logic                       store_strb,
  input  logic [7:0]                 start_dly,
  input  logic signed [ADC_W-1:0]    pedestal,
  output logic                       bunch_strb,
  output logic signed [CHARGE_W-1:0] charge_out,
  output logic                       charge_valid,
  output logic                       train_done
);

  localparam int SMP_W   = clog2(NUM_SMPLS_INTEG);
  localparam int BUNCH_W = clog2(NUM_BUNCHES);
  localparam logic [SMP_W-1:0]   SMP_LAST   = SMP_W'(NUM_SMPLS_INTEG - 1);
  localparam logic [BUNCH_W-1:0] BUNCH_LAST = BUNCH_W'(NUM_BUNCHES - 1);

  // The pedestal register shifts the sample stream by one cycle, so the window starts one later.
`ifdef BUNCH_CHARGE_PEDESTAL_SUB_EN
  localparam logic [8:0] DLY_EXTRA = 9'd1;
`else
  localparam logic [8:0] DLY_EXTRA = 9'd0;
`endif

  state_t                     state_q;
  state_t                     state_d;
  logic                       strb_q;
  logic                       rise;
  logic                       abort;
  logic                       in_integ;
  logic                       smp_last;
  logic                       bunch_last;
  logic [8:0]                 dly_load;
  logic [8:0]                 dly_ctr;
  logic [SMP_W-1:0]           smp_ctr;
  logic [BUNCH_W-1:0]         bunch_ctr;
  logic                       valid_q;
  logic signed [CHARGE_W-1:0] acc;
  logic signed [CHARGE_W-1:0] charge_hold;

  assign rise         = store_strb & ~strb_q;
  assign abort        = (state_q != IDLE) & ~store_strb;
  assign in_integ     = (state_q == INTEG);
  assign smp_last     = (smp_ctr == SMP_LAST);
  assign bunch_last   = (bunch_ctr == BUNCH_LAST);
  assign dly_load     = {1'b0, start_dly} + DLY_EXTRA;
  assign bunch_strb   = in_integ && (smp_ctr == '0);
  assign charge_valid = valid_q;
  // The accumulator still holds the finished bunch during the valid cycle.
  assign charge_out   = valid_q ? acc : charge_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = (dly_load == 9'd0) ? INTEG : DELAY;
      end
      DELAY: begin
        if (!store_strb)            state_d = IDLE;
        else if (dly_ctr <= 9'd1)   state_d = INTEG;
      end
      INTEG: begin
        if (!store_strb)                 state_d = IDLE;
        else if (smp_last && bunch_last) state_d = DONE;
      end
      DONE: begin
        if (!store_strb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q      <= 1'b0;
      dly_ctr     <= '0;
      smp_ctr     <= '0;
      bunch_ctr   <= '0;
      valid_q     <= 1'b0;
      train_done  <= 1'b0;
      charge_hold <= '0;
    end else begin
      strb_q     <= store_strb;
      valid_q    <= 1'b0;
      train_done <= 1'b0;
      if (abort) begin
        dly_ctr     <= '0;
        smp_ctr     <= '0;
        bunch_ctr   <= '0;
        charge_hold <= '0;
      end else begin
        if (state_q == IDLE) begin
          dly_ctr <= dly_load;
        end else if (state_q == DELAY) begin
          dly_ctr <= dly_ctr - 9'd1;
        end
        if (in_integ) begin
          if (smp_last) begin
            smp_ctr    <= '0;
            valid_q    <= 1'b1;
            train_done <= bunch_last;
            bunch_ctr  <= bunch_last ? '0 : bunch_ctr + 1'b1;
          end else begin
            smp_ctr <= smp_ctr + 1'b1;
          end
        end
        if (valid_q) charge_hold <= acc;
      end
    end
  end

  bunch_integ_accum #(
    .ADC_W    (ADC_W),
    .CHARGE_W (CHARGE_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sum_in),
    .pedestal (pedestal),
    .first    (bunch_strb),
    .enable   (in_integ),
    .clear    (abort),
    .acc      (acc)
  );

endmodule

// File: doc/bunch_charge_integ.md
Name: bunch_charge_integ

Overview:
- Upstream stage of the feedback multiplier.
- Integrates a fixed number of ADC sum-channel samples per bunch while the store strobe is high.
- Produces the signed per-bunch charge word and the bunch strobe that the multiplier consumes, both aligned to the sample stream.
- A programmable start delay places the first integration window on the first bunch of the train.

Parameters:
- NUM_SMPLS_INTEG, 4, samples integrated per bunch (1..64).
- NUM_BUNCHES, 3, bunches per train (1..16).
- ADC_W, 14, width of the signed ADC sample.
- CHARGE_W, 21, width of the signed charge output.

Ports:
- clk  in  1  sample clock; one ADC sample per cycle.
- rst_n  in  1  asynchronous active-low reset.
- sum_in  in  ADC_W  signed sum-channel ADC sample.
- store_strb  in  1  high for the whole train window; low aborts.
- start_dly  in  8  samples to skip after store_strb rises, before bunch 0.
- pedestal  in  ADC_W  signed per-sample baseline (used only with the optional feature).
- bunch_strb  out  1  one-cycle pulse on the first sample of each bunch.
- charge_out  out  CHARGE_W  signed integrated charge of the last completed bunch.
- charge_valid  out  1  one-cycle pulse when charge_out updates.
- train_done  out  1  one-cycle pulse after the last bunch completes.

Behaviour:
- Reset (async, rst_n=0): all outputs and internal registers are 0; state is IDLE.
- States and transitions:
  - IDLE: on the store_strb rising edge (registered 0->1) go to DELAY and load dly_ctr with start_dly. If start_dly=0, go straight to INTEG.
  - DELAY: decrement dly_ctr each cycle; at 0, go to INTEG.
  - INTEG: the first INTEG cycle is sample 0 of bunch 0. smp_ctr runs 0..NUM_SMPLS_INTEG-1; bunch_ctr runs 0..NUM_BUNCHES-1.
  - DONE: entered after the last sample of the last bunch; stays until store_strb is low, then returns to IDLE. No retrigger without a fresh rising edge.
- bunch_strb: high exactly in the cycle the state is INTEG and smp_ctr=0. It is combinationally decoded from registered state, so it aligns with that cycle's sum_in.
- Accumulation:
  - At smp_ctr=0, acc <= sext(sum_in); otherwise acc <= acc + sext(sum_in).
  - acc is CHARGE_W bits wide. The parameter range (max 64 × 2^13 < 2^20) guarantees no overflow, so no saturation is needed.
- Output update:
  - The cycle after the last sample of a bunch: charge_out <= final acc and charge_valid=1 for one cycle. Latency is 1 clk from the last sample.
  - charge_out holds its value until the next update.
- train_done: pulses together with the final charge_valid of the train, and the state enters DONE.
- store_strb falling in any non-IDLE state: the next cycle returns to IDLE and clears acc, counters, charge_out, charge_valid and bunch_strb. No partial-bunch result is emitted. This mirrors the downstream clear-on-low behaviour.
- store_strb low in IDLE: outputs stay 0.
- If store_strb rises and falls within DELAY, nothing is emitted.
- NUM_SMPLS_INTEG=1: bunch_strb is high every INTEG cycle, and charge_valid follows each sample by 1 cycle.

Optional Feature:
- Macro: BUNCH_CHARGE_PEDESTAL_SUB_EN.
- Defined: each sample becomes sext(sum_in) - sext(pedestal), computed at ADC_W+1 bits before accumulation. A one-cycle register is inserted on the difference, so bunch_strb and all counters are delayed one cycle to stay aligned, and charge_valid latency from the last raw sample becomes 2 clk.
- Undefined: the pedestal port is present but ignored. The latency and alignment above apply unchanged.

Decomposition:
- Shared package bunch_fb_pkg holds:
  - the state enum (IDLE, DELAY, INTEG, DONE);
  - CHARGE_W and ADC_W defaults;
  - a localparam function clog2 for counter widths.
- Sub-module bunch_integ_accum: the accumulator with load/add select and the optional pedestal subtract. It takes sample, first and enable; it returns acc.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset mid-INTEG: assert rst_n=0 during bunch 1 -> all outputs 0 immediately; IDLE after release, with no output until a new store_strb rising edge.
- Basic train: defaults, start_dly=2, sum_in constant 100, store_strb held high -> bunch_strb at cycles 3, 7, 11 after the rising edge; charge_out=400 with charge_valid at cycles 7, 11, 15; train_done with the third charge_valid.
- Negative extremes: sum_in=-8192 for all samples, NUM_SMPLS_INTEG=64 -> charge_out=-524288 exactly, no wrap.
- Abort: store_strb drops after sample 2 of bunch 1 -> no charge_valid for bunch 1; next cycle charge_out=0 and state IDLE.
- start_dly=0 with ramp sum_in=0,1,2,3... -> bunch_strb in the first cycle after the edge; bunch 0 charge=0+1+2+3=6, bunch 1 charge=22.
- With BUNCH_CHARGE_PEDESTAL_SUB_EN, pedestal=50, sum_in=100 -> charge_out=200; every event is shifted 1 cycle later than in the basic-train case.
